// File: rtl/rv_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv_instr_encoder
//
// Sequential RV32I instruction encoder and instruction-memory loader. Takes
// symbolic instruction fields over a valid/ready handshake, range-checks the
// immediate, packs a 32-bit RV32I word and writes it to consecutive
// instruction-memory word addresses starting at 0.
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         synchronous active-high reset
//   clear_i       rewind write pointer to 0 and clear the sticky error code
//   valid_i       instruction fields valid
//   ready_o       encoder can accept (not in reset, not clearing, not full)
//   class_i       0 R, 1 I-imm, 2 LOAD, 3 JALR, 4 S, 5 B, 6 LUI, 7 AUIPC,
//                 8 JAL, 9..15 illegal
//   rd_i/rs1_i/rs2_i  register indices
//   funct3_i      funct3 (R, I-imm, LOAD, S, B)
//   funct7_i      funct7 (R only)
//   imm_i         full-width signed immediate / byte offset
//   imem_we_o     instruction-memory write strobe
//   imem_addr_o   word address of the write
//   imem_wdata_o  encoded instruction word
//   count_o       legal words accepted since reset/clear
//   full_o        count_o == 2**ADDR_W
//   err_o         one-cycle pulse for a rejected instruction
//   err_code_o    sticky code of last rejection:
//                 01 illegal class, 10 imm out of range, 11 imm misaligned
// ---------------------------------------------------------------------------
module rv_instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        class_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  // Symbolic instruction classes as presented on class_i.
  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_IMM   = 4'd1,
    CLS_LOAD  = 4'd2,
    CLS_JALR  = 4'd3,
    CLS_S     = 4'd4,
    CLS_B     = 4'd5,
    CLS_LUI   = 4'd6,
    CLS_AUIPC = 4'd7,
    CLS_JAL   = 4'd8
  } instr_class_e;

  // RV32I major opcodes.
  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_CLASS = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_ALIGN = 2'b11
  } err_code_e;

  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W:0]   count_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  err_code_e         err_code_q;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;

  assign full_o  = (count_q == CNT_DEPTH);
  assign ready_o = ~rst_i & ~clear_i & ~full_o;
  assign accept  = valid_i & ready_o;

  // -------------------------------------------------------------------------
  // Immediate range predicates: imm_i must equal the sign extension of its
  // low N bits, i.e. bits [31:N-1] are all equal.
  // -------------------------------------------------------------------------
  logic sext12;
  logic sext13;
  logic sext21;

  assign sext12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign sext13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign sext21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // -------------------------------------------------------------------------
  // Pack and check
  // -------------------------------------------------------------------------
  logic [31:0] word;
  logic        legal_class;
  logic        aligned;
  logic        imm_ok;
  err_code_e   chk_code;

  always_comb begin
    word        = '0;
    legal_class = 1'b1;
    aligned     = 1'b1;
    imm_ok      = 1'b1;

    case (class_i)
      CLS_R: begin
        word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      end
      CLS_IMM: begin
        // Shift-immediates carry funct7 in imm[11:5]; no special case here.
        word   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM};
        imm_ok = sext12;
      end
      CLS_LOAD: begin
        word   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        imm_ok = sext12;
      end
      CLS_JALR: begin
        word   = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
        imm_ok = sext12;
      end
      CLS_S: begin
        word   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        imm_ok = sext12;
      end
      CLS_B: begin
        word    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], OP_BRANCH};
        aligned = ~imm_i[0];
        imm_ok  = sext13;
      end
      CLS_LUI: begin
        word   = {imm_i[31:12], rd_i, OP_LUI};
        imm_ok = ~(|imm_i[11:0]);
      end
      CLS_AUIPC: begin
        word   = {imm_i[31:12], rd_i, OP_AUIPC};
        imm_ok = ~(|imm_i[11:0]);
      end
      CLS_JAL: begin
        word    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        aligned = ~imm_i[0];
        imm_ok  = sext21;
      end
      default: begin
        legal_class = 1'b0;
      end
    endcase

    // Priority: illegal class, then misalignment, then range.
    if (!legal_class) begin
      chk_code = ERR_CLASS;
    end else if (!aligned) begin
      chk_code = ERR_ALIGN;
    end else if (!imm_ok) begin
      chk_code = ERR_RANGE;
    end else begin
      chk_code = ERR_NONE;
    end
  end

  // -------------------------------------------------------------------------
  // Write pointer, output stage and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      if (clear_i) begin
        count_q    <= '0;
        err_code_q <= ERR_NONE;
      end else if (accept) begin
        if (chk_code == ERR_NONE) begin
          we_q    <= 1'b1;
          addr_q  <= count_q[ADDR_W-1:0];
          wdata_q <= word;
          count_q <= count_q + CNT_ONE;
        end else begin
          err_q      <= 1'b1;
          err_code_q <= chk_code;
        end
      end
    end
  end

  // Strobes are masked by rst_i so that an output-stage write or error pulse
  // pending when reset arrives never reaches memory during the reset cycle.
  assign imem_we_o    = we_q & ~rst_i;
  assign err_o        = err_q & ~rst_i;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign err_code_o   = err_code_q;

endmodule
